// File: rtl/display_scan_mux.sv
// Four-digit seven-segment scan controller: guard/show dwell per digit, tear-free
// frame-boundary display update and optional leading-zero suppression.
module display_scan_mux #(
  parameter int unsigned SHOW_CYCLES  = 50000,
  parameter int unsigned GUARD_CYCLES = 500,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dataIn16,
  input  logic        load,
  input  logic        lzBlank,
  input  logic        enable,
  output logic [3:0]  nibbleOut,
  output logic [3:0]  anodeOut,
  output logic [1:0]  digitIdx,
  output logic        frameDone
);

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      pending_q, pending_d;
  logic [15:0]      display_q, display_d;
  logic [3:0]       anode_q, anode_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_end;

  // Digit k>0 is dark when it and every higher nibble are zero.
  function automatic logic is_blanked(input logic [15:0] disp, input logic [1:0] k,
                                      input logic lz);
    logic blank;
    blank = 1'b0;
    case (k)
      2'd1:    blank = (disp[15:4] == 12'h000);
      2'd2:    blank = (disp[15:8] == 8'h00);
      2'd3:    blank = (disp[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
    return lz && blank;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_GUARD;
      digit_q      <= 2'd0;
      cnt_q        <= '0;
      pending_q    <= 16'h0000;
      display_q    <= 16'h0000;
      anode_q      <= 4'b1111;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      display_q    <= display_d;
      anode_q      <= anode_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    display_d = display_q;
    frame_end = 1'b0;

    if (load) pending_d = dataIn16;

    if (!enable) begin
      state_d = ST_GUARD;
      digit_d = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            cnt_d   = '0;
            state_d = ST_SHOW;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            cnt_d     = '0;
            state_d   = ST_GUARD;
            digit_d   = digit_q + 2'd1;
            frame_end = (digit_q == 2'd3);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_GUARD;
      endcase
    end

    // Display only swaps between frames, so a frame never mixes two values.
    if (frame_end) display_d = load ? dataIn16 : pending_q;
  end

  // Outputs are computed from next-state values and registered.
  always_comb begin
    anode_d      = 4'b1111;
    frame_done_d = frame_end;
    if (state_d == ST_SHOW && !is_blanked(display_d, digit_d, lzBlank)) begin
      anode_d[digit_d] = 1'b0;
    end
  end

  assign nibbleOut = display_q[4*digit_q +: 4];
  assign anodeOut  = anode_q;
  assign digitIdx  = digit_q;
  assign frameDone = frame_done_q;

endmodule
